// File: rtl/rv32i_multiplier_iterative_unit_if.sv
// Request/response bundle between the execute-stage shifter controlpath
// (requester) and the iterative multiplier (responder).
interface rv32i_multiplier_iterative_unit_if;
   logic        multiplier_en;
   logic [15:0] multiplier_operand_one;
   logic [15:0] multiplier_operand_two;
   logic        multiplier_valid;
   logic [31:0] multiplier_result;
   logic        multiplier_busy;

   // Requester side: raises en with operands, watches for valid.
   modport master (
      output multiplier_en,
      output multiplier_operand_one,
      output multiplier_operand_two,
      input  multiplier_valid,
      input  multiplier_result,
      input  multiplier_busy
   );

   // Multiplier side.
   modport slave (
      input  multiplier_en,
      input  multiplier_operand_one,
      input  multiplier_operand_two,
      output multiplier_valid,
      output multiplier_result,
      output multiplier_busy
   );
endinterface

// File: rtl/rv32i_multiplier_iterative_unit.sv
// Iterative unsigned 16x16->32 shift-and-add multiplier.
// Consumes RADIX_BITS multiplier bits per BUSY cycle (legal: 1,2,4,8,16),
// so an operation takes K = 16/RADIX_BITS busy edges after capture.
module rv32i_multiplier_iterative_unit #(
   parameter int RADIX_BITS = 4
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   rv32i_multiplier_iterative_unit_if.slave  bus
);

   localparam int         K        = 16 / RADIX_BITS;
   localparam logic [4:0] CNT_LAST = 5'(K - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE_WAIT
   } state_t;

   state_t      state_q;
   logic [31:0] mcand_q;
   logic [15:0] mplier_q;
   logic [31:0] acc_q;
   logic [4:0]  cnt_q;
   logic [31:0] result_q;
   logic        valid_q;
   logic        busy_q;

   logic [31:0] digit_d;
   logic [31:0] partial_d;
   logic [31:0] accSum_d;

   // Partial product of the shifted multiplicand and the low multiplier digit.
   always_comb begin
      digit_d   = 32'(mplier_q[RADIX_BITS-1:0]);
      partial_d = mcand_q * digit_d;
      accSum_d  = acc_q + partial_d;
   end

   // Single control FSM; all outputs are registered alongside the state.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               valid_q <= 1'b0;
               if (bus.multiplier_en) begin
                  mcand_q  <= {16'h0, bus.multiplier_operand_one};
                  mplier_q <= bus.multiplier_operand_two;
                  acc_q    <= '0;
                  cnt_q    <= CNT_LAST;
                  state_q  <= BUSY;
                  busy_q   <= 1'b1;
               end
            end
            BUSY: begin
               if (!bus.multiplier_en) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  acc_q    <= accSum_d;
                  mcand_q  <= mcand_q << RADIX_BITS;
                  mplier_q <= mplier_q >> RADIX_BITS;
                  cnt_q    <= cnt_q - 5'd1;
                  if (cnt_q == 5'd0) begin
                     result_q <= accSum_d;
                     valid_q  <= 1'b1;
                     state_q  <= DONE_WAIT;
                  end
               end
            end
            DONE_WAIT: begin
               valid_q <= 1'b0;
               if (!bus.multiplier_en) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.multiplier_valid  = valid_q;
   assign bus.multiplier_result = result_q;
   assign bus.multiplier_busy   = busy_q;

endmodule

// File: tb/tb_rv32i_multiplier_iterative_unit.sv
// Self-checking bench for the iterative multiplier: directed vectors on a
// RADIX_BITS=4 instance checked every cycle against a transaction-level model,
// plus random sweeps on RADIX_BITS 1,2,8,16 instances.
module tb_rv32i_multiplier_iterative_unit;

   localparam int MAIN_RADIX = 4;
   localparam int MAIN_K     = 16 / MAIN_RADIX;

   logic clk;
   logic rst;
   logic sweepRst;
   logic armed;
   int   checks;
   int   errors;

   rv32i_multiplier_iterative_unit_if mainIf ();

   rv32i_multiplier_iterative_unit #(.RADIX_BITS(MAIN_RADIX)) uDut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (mainIf.slave)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual %h required %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic [15:0] a,
                                input logic [15:0] b);
      mainIf.multiplier_en          = en;
      mainIf.multiplier_operand_one = a;
      mainIf.multiplier_operand_two = b;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Transaction-level model: an op in flight counts edges until K have elapsed.
   bit          mInOp;
   bit          mWaitLow;
   int          mEdges;
   logic [31:0] mProd;
   logic [31:0] mResult;
   logic        mValid;
   logic        mBusy;

   // Advance the model on each rising edge from the inputs the bench drove.
   always @(posedge clk) begin
      if (rst) begin
         mInOp = 0; mWaitLow = 0; mEdges = 0;
         mResult = '0; mValid = 1'b0; mBusy = 1'b0;
      end else begin
         mValid = 1'b0;
         if (mInOp) begin
            if (!mainIf.multiplier_en) mInOp = 0;
            else begin
               mEdges++;
               if (mEdges == MAIN_K) begin
                  mResult = mProd; mValid = 1'b1; mInOp = 0; mWaitLow = 1;
               end
            end
         end else if (mWaitLow) begin
            if (!mainIf.multiplier_en) mWaitLow = 0;
         end else if (mainIf.multiplier_en) begin
            mInOp  = 1;
            mEdges = 0;
            mProd  = {16'h0, mainIf.multiplier_operand_one} * {16'h0, mainIf.multiplier_operand_two};
         end
         mBusy = mInOp || mWaitLow;
      end
   end

   // Compare the main DUT against the model on every falling edge.
   always @(negedge clk) begin
      if (armed) begin
         checkOutput("cmp_valid", {31'b0, mainIf.multiplier_valid}, {31'b0, mValid});
         checkOutput("cmp_result", mainIf.multiplier_result, mResult);
         checkOutput("cmp_busy", {31'b0, mainIf.multiplier_busy}, {31'b0, mBusy});
      end
   end

   // Start an op, scramble the operand ports after capture, wait for valid.
   task automatic runOp(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] expProd, input string name);
      int cyc;
      applyStimulus(1'b1, a, b);
      tick(1);
      applyStimulus(1'b1, ~a, b ^ 16'h5A5A);
      cyc = 1;
      while (!mainIf.multiplier_valid && cyc < 64) begin
         tick(1);
         cyc++;
      end
      checkOutput({name, "_latency"}, 32'(cyc), 32'(MAIN_K + 1));
      checkOutput({name, "_result"}, mainIf.multiplier_result, expProd);
   endtask

   // Random sweeps over the other radix settings, each with its own instance.
   for (genvar g = 0; g < 4; g++) begin : gSweep
      localparam int R  = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
      localparam int KS = 16 / R;
      bit done;

      rv32i_multiplier_iterative_unit_if sIf ();

      rv32i_multiplier_iterative_unit #(.RADIX_BITS(R)) uSweep (
         .i_clk (clk),
         .i_rst (sweepRst),
         .bus   (sIf.slave)
      );

      // Drive 1000 ops, checking product and latency of each.
      initial begin
         logic [15:0] a;
         logic [15:0] b;
         int          cyc;
         done = 0;
         sIf.multiplier_en          = 1'b0;
         sIf.multiplier_operand_one = '0;
         sIf.multiplier_operand_two = '0;
         repeat (4) @(negedge clk);
         for (int n = 0; n < 1000; n++) begin
            if (n == 0) begin a = 16'hFFFF; b = 16'hFFFF; end
            else if (n == 1) begin a = 16'h0000; b = 16'hABCD; end
            else if (n == 2) begin a = 16'h0001; b = 16'h8001; end
            else begin a = 16'($urandom); b = 16'($urandom); end
            sIf.multiplier_en          = 1'b1;
            sIf.multiplier_operand_one = a;
            sIf.multiplier_operand_two = b;
            @(negedge clk);
            sIf.multiplier_operand_one = 16'($urandom);
            cyc = 1;
            while (!sIf.multiplier_valid && cyc < 64) begin
               @(negedge clk);
               cyc++;
            end
            checkOutput($sformatf("sweep_r%0d_latency", R), 32'(cyc), 32'(KS + 1));
            checkOutput($sformatf("sweep_r%0d_result", R), sIf.multiplier_result,
                        {16'h0, a} * {16'h0, b});
            sIf.multiplier_en = 1'b0;
            @(negedge clk);
         end
         done = 1;
      end
   end

   // Directed sequence on the main instance.
   initial begin
      int guard;
      checks   = 0;
      errors   = 0;
      armed    = 1'b0;
      rst      = 1'b1;
      sweepRst = 1'b1;
      applyStimulus(1'b0, 16'h0, 16'h0);
      @(posedge clk);
      armed = 1'b1;
      tick(2);
      checkOutput("reset_valid", {31'b0, mainIf.multiplier_valid}, 32'h0);
      checkOutput("reset_result", mainIf.multiplier_result, 32'h0);
      checkOutput("reset_busy", {31'b0, mainIf.multiplier_busy}, 32'h0);
      rst      = 1'b0;
      sweepRst = 1'b0;
      tick(1);

      // Full-scale product with en held, then one-cycle pulse and hold-off.
      runOp(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "ffff");
      checkOutput("model_pin_ffff", mResult, 32'hFFFE0001);
      tick(1);
      checkOutput("pulse_width", {31'b0, mainIf.multiplier_valid}, 32'h0);
      for (int i = 0; i < 10; i++) begin
         tick(1);
         checkOutput("hold_no_valid", {31'b0, mainIf.multiplier_valid}, 32'h0);
         checkOutput("hold_busy", {31'b0, mainIf.multiplier_busy}, 32'h1);
         checkOutput("hold_result", mainIf.multiplier_result, 32'hFFFE0001);
      end
      applyStimulus(1'b0, 16'h0, 16'h0);
      tick(2);
      checkOutput("release_busy", {31'b0, mainIf.multiplier_busy}, 32'h0);

      // Abort mid-operation keeps the earlier product.
      applyStimulus(1'b1, 16'h0003, 16'h0007);
      tick(3);
      applyStimulus(1'b0, 16'h0, 16'h0);
      tick(MAIN_K + 3);
      checkOutput("abort_busy", {31'b0, mainIf.multiplier_busy}, 32'h0);
      checkOutput("abort_result", mainIf.multiplier_result, 32'hFFFE0001);

      // Shift-style operands.
      runOp(16'h1234, 16'h0010, 32'h00012340, "shift_1234");
      applyStimulus(1'b0, 16'h0, 16'h0);
      tick(2);
      runOp(16'h8000, 16'h0002, 32'h00010000, "shift_8000");
      applyStimulus(1'b0, 16'h0, 16'h0);
      tick(2);
      runOp(16'h0000, 16'hABCD, 32'h00000000, "zero");
      applyStimulus(1'b0, 16'h0, 16'h0);
      tick(2);

      // Reset in the middle of an op, then a fresh op.
      runOp(16'h00FF, 16'h0101, 32'h0000FFFF, "pre_reset");
      applyStimulus(1'b0, 16'h0, 16'h0);
      tick(2);
      applyStimulus(1'b1, 16'h1111, 16'h2222);
      tick(2);
      rst = 1'b1;
      tick(1);
      checkOutput("midrst_valid", {31'b0, mainIf.multiplier_valid}, 32'h0);
      checkOutput("midrst_result", mainIf.multiplier_result, 32'h0);
      checkOutput("midrst_busy", {31'b0, mainIf.multiplier_busy}, 32'h0);
      rst = 1'b0;
      applyStimulus(1'b0, 16'h0, 16'h0);
      tick(1);
      runOp(16'h0003, 16'h0005, 32'h0000000F, "after_reset");
      applyStimulus(1'b0, 16'h0, 16'h0);
      tick(2);

      guard = 0;
      while (!(gSweep[0].done && gSweep[1].done && gSweep[2].done && gSweep[3].done)
             && guard < 40000) begin
         tick(1);
         guard++;
      end
      checkOutput("sweep_complete", {31'b0, gSweep[0].done && gSweep[1].done
                  && gSweep[2].done && gSweep[3].done}, 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
